mem_access: RTL

- Memory/branch-resolve stage; sits directly downstream of the execute stage and upstream of writeback.
- Consumes execute's registered outputs: result, rs2 value, mem controls, branch op/target, alu_non_zero.
- Performs one data-bus load/store per instruction with a req/ack handshake, stalling the pipeline while waiting.
- Resolves branches against the fetch prediction, drives flush/redirect, and registers rd/result toward writeback.

---
 rtl/mem_access_pkg.sv | 34 +++
 rtl/mem_access_load_align.sv | 59 +++++
 rtl/mem_access.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the memory/branch-resolve stage.
//   - Branch op codes (BRANCH_*), data width codes (MEM_WIDTH_*).
//   - Bus FSM state type (MEM_IDLE / MEM_WAIT).
//   - mem_align_mask(): low address bits that must be zero for a width.
package mem_access_pkg;

    localparam logic [2:0] BRANCH_NONE     = 3'd0;
    localparam logic [2:0] BRANCH_JUMP     = 3'd1;
    localparam logic [2:0] BRANCH_ZERO     = 3'd2;
    localparam logic [2:0] BRANCH_NON_ZERO = 3'd3;

    localparam logic [1:0] MEM_WIDTH_B = 2'd0;
    localparam logic [1:0] MEM_WIDTH_H = 2'd1;
    localparam logic [1:0] MEM_WIDTH_W = 2'd2;
    localparam logic [1:0] MEM_WIDTH_D = 2'd3;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_t;

    // Offset bits that must be clear for a naturally aligned access.
    function automatic logic [2:0] mem_align_mask(input logic [1:0] width);
        logic [2:0] mask;
        case (width)
            MEM_WIDTH_B: mask = 3'b000;
            MEM_WIDTH_H: mask = 3'b001;
            MEM_WIDTH_W: mask = 3'b011;
            default:     mask = 3'b111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// mem_access_load_align: combinational lane steering for one doubleword bus.
//   i_offset       byte offset inside the doubleword (already aligned by caller)
//   i_width        MEM_WIDTH_* code
//   i_zero_extend  1 = zero-extend loads, 0 = sign-extend
//   i_rdata        raw doubleword read from the bus
//   i_store_data   store value (low bytes significant)
//   o_load_data    extracted and extended load value
//   o_wdata        store data replicated across all lanes
//   o_wmask        byte enables for the store
module mem_access_load_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  i_offset,
    input  logic [1:0]  i_width,
    input  logic        i_zero_extend,
    input  logic [63:0] i_rdata,
    input  logic [63:0] i_store_data,
    output logic [63:0] o_load_data,
    output logic [63:0] o_wdata,
    output logic [7:0]  o_wmask
);

    logic [63:0] w_shifted;

    // Bring the addressed byte down to lane 0 before width selection.
    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    always_comb begin
        o_load_data = w_shifted;
        o_wdata     = i_store_data;
        o_wmask     = 8'hFF;
        unique case (i_width)
            MEM_WIDTH_B: begin
                o_load_data = i_zero_extend ? {56'd0, w_shifted[7:0]}
                                            : {{56{w_shifted[7]}}, w_shifted[7:0]};
                o_wdata     = {8{i_store_data[7:0]}};
                o_wmask     = 8'h01 << i_offset;
            end
            MEM_WIDTH_H: begin
                o_load_data = i_zero_extend ? {48'd0, w_shifted[15:0]}
                                            : {{48{w_shifted[15]}}, w_shifted[15:0]};
                o_wdata     = {4{i_store_data[15:0]}};
                o_wmask     = 8'h03 << i_offset;
            end
            MEM_WIDTH_W: begin
                o_load_data = i_zero_extend ? {32'd0, w_shifted[31:0]}
                                            : {{32{w_shifted[31]}}, w_shifted[31:0]};
                o_wdata     = {2{i_store_data[31:0]}};
                o_wmask     = 8'h0F << i_offset;
            end
            MEM_WIDTH_D: begin
                o_load_data = w_shifted;
                o_wdata     = i_store_data;
                o_wmask     = 8'hFF;
            end
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access: memory / branch-resolve pipeline stage (execute -> here -> writeback).
//   Inputs : execute-stage registered outputs (valid, mem controls, branch op, result,
//            rs2, pcs), data bus read data and ack.
//   Outputs: data bus req/we/addr/wdata/wmask, stall (hold upstream), flush and
//            redirect_pc on mispredict, bus_error pulse on timeout, misaligned pulse,
//            and registered valid/rd/rd_write/rd_value toward writeback.
//   BUS_TIMEOUT: WAIT cycles tolerated before the access is aborted (1..65535).
//   Build option MEM_MISALIGN_TRAP_EN: misaligned accesses are trapped (no bus request,
//   misaligned_out pulse, no rd write). Without it, misaligned_out is 0 and the
//   offset is rounded down to the width's natural alignment.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    input  logic        branch_predicted_taken_in,
    input  logic        alu_non_zero_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  mem_width_in,
    input  logic        mem_zero_extend_in,
    input  logic [2:0]  branch_op_in,
    input  logic [8:0]  rd_in,
    input  logic        rd_write_in,
    input  logic [63:0] result_in,
    input  logic [63:0] rs2_value_in,
    input  logic [63:0] branch_pc_in,
    input  logic [63:0] pc_in,
    output logic        data_req_out,
    output logic        data_we_out,
    output logic [63:0] data_addr_out,
    output logic [63:0] data_wdata_out,
    output logic [7:0]  data_wmask_out,
    input  logic [63:0] data_rdata_in,
    input  logic        data_ack_in,
    output logic        stall_out,
    output logic        flush_out,
    output logic [63:0] redirect_pc_out,
    output logic        bus_error_out,
    output logic        misaligned_out,
    output logic        valid_out,
    output logic [8:0]  rd_out,
    output logic        rd_write_out,
    output logic [63:0] rd_value_out
);

    localparam logic [15:0] TIMEOUT_LAST = 16'(BUS_TIMEOUT - 1);

    logic [1:0]  w_width;
    logic [2:0]  w_raw_off;
    logic [2:0]  w_align_mask;
    logic [2:0]  w_off;
    logic        w_misaligned;
    logic        w_mis_trap;
    logic        w_mem_op;
    logic        w_req;
    logic        w_abort;
    logic        w_stall;
    logic        w_taken;
    logic [63:0] w_load_data;
    logic        w_unused_width;

    mem_access_pkg::mem_state_t r_state, w_state_next;
    logic [15:0] r_wait_cnt, w_wait_cnt_next;

    logic        r_valid;
    logic [8:0]  r_rd;
    logic        r_rd_write;
    logic [63:0] r_rd_value;
    logic        r_bus_error;

    assign w_width        = mem_width_in[1:0];
    assign w_unused_width = mem_width_in[2];
    assign w_raw_off      = result_in[2:0];
    assign w_align_mask   = mem_align_mask(w_width);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned = |(w_raw_off & w_align_mask);
    assign w_off        = w_raw_off;
`else
    assign w_misaligned = 1'b0;
    assign w_off        = w_raw_off & ~w_align_mask;
`endif

    assign w_mis_trap = valid_in & (mem_read_in | mem_write_in) & w_misaligned;
    assign w_mem_op   = valid_in & (mem_read_in | mem_write_in) & ~w_misaligned;

    mem_access_load_align u_load_align (
        .i_offset      (w_off),
        .i_width       (w_width),
        .i_zero_extend (mem_zero_extend_in),
        .i_rdata       (data_rdata_in),
        .i_store_data  (rs2_value_in),
        .o_load_data   (w_load_data),
        .o_wdata       (data_wdata_out),
        .o_wmask       (data_wmask_out)
    );

    // Bus FSM state and WAIT-cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= MEM_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = r_wait_cnt;
        w_req           = 1'b0;
        w_abort         = 1'b0;
        unique case (r_state)
            MEM_IDLE: begin
                w_req           = w_mem_op;
                w_wait_cnt_next = '0;
                // Same-cycle ack completes with zero wait and never leaves IDLE.
                if (w_mem_op && !data_ack_in) begin
                    w_state_next = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                w_req = 1'b1;
                if (data_ack_in) begin
                    w_state_next    = MEM_IDLE;
                    w_wait_cnt_next = '0;
                end else if (r_wait_cnt == TIMEOUT_LAST) begin
                    w_abort         = 1'b1;
                    w_state_next    = MEM_IDLE;
                    w_wait_cnt_next = '0;
                end else begin
                    w_wait_cnt_next = r_wait_cnt + 16'd1;
                end
            end
            default: begin
                w_state_next    = MEM_IDLE;
                w_wait_cnt_next = '0;
            end
        endcase
    end

    assign w_stall = w_req & ~data_ack_in & ~w_abort;

    assign data_req_out  = w_req;
    assign data_we_out   = w_req & mem_write_in;
    assign data_addr_out = {result_in[63:3], 3'b000};
    assign stall_out     = w_stall;

    // Branch resolution; a branch sharing a mem op resolves once the access completes.
    always_comb begin
        case (branch_op_in)
            BRANCH_NONE:     w_taken = 1'b0;
            BRANCH_JUMP:     w_taken = 1'b1;
            BRANCH_ZERO:     w_taken = ~alu_non_zero_in;
            BRANCH_NON_ZERO: w_taken = alu_non_zero_in;
            default:         w_taken = 1'b0;
        endcase
    end

    assign flush_out       = valid_in & ~w_stall & (w_taken != branch_predicted_taken_in);
    assign redirect_pc_out = w_taken ? branch_pc_in : pc_in + 64'd4;

    // Writeback registers: bubble (valid/rd_write low) while stalled, data held.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_rd        <= '0;
            r_rd_write  <= 1'b0;
            r_rd_value  <= '0;
            r_bus_error <= 1'b0;
        end else if (!w_stall) begin
            r_valid     <= valid_in;
            r_rd        <= rd_in;
            r_rd_write  <= rd_write_in & valid_in & ~w_abort & ~w_mis_trap;
            r_rd_value  <= mem_read_in ? w_load_data : result_in;
            r_bus_error <= w_abort;
        end else begin
            r_valid     <= 1'b0;
            r_rd_write  <= 1'b0;
            r_bus_error <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic r_misaligned;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misaligned <= 1'b0;
        end else if (!w_stall) begin
            r_misaligned <= w_mis_trap;
        end else begin
            r_misaligned <= 1'b0;
        end
    end

    assign misaligned_out = r_misaligned;
`else
    assign misaligned_out = 1'b0;
`endif

    assign valid_out     = r_valid;
    assign rd_out        = r_rd;
    assign rd_write_out  = r_rd_write;
    assign rd_value_out  = r_rd_value;
    assign bus_error_out = r_bus_error;

endmodule
